// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per clock after a start request.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module shift_sub_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] quotient_o,
    output logic [N-1:0] remainder_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         div_by_zero_o
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     r_q, r_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   dvsr_q, dvsr_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [2*N:0]   rq_shift;
    logic [N:0]     r_shift;
    logic [N-1:0]   q_shift;
    logic [N:0]     r_step;
    logic [N-1:0]   q_step;

    // One restoring step on the concatenated {R,Q} register pair.
    always_comb begin
        rq_shift = {r_q, q_q} << 1;
        r_shift  = rq_shift[2*N:N];
        q_shift  = rq_shift[N-1:0];
        if (r_shift >= {1'b0, dvsr_q}) begin
            r_step = r_shift - {1'b0, dvsr_q};
            q_step = q_shift | N'(1);
        end else begin
            r_step = r_shift;
            q_step = q_shift;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend_i;
                        dvsr_d  = divisor_i;
                        r_d     = '0;
                        cnt_d   = CW'(N);
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_step;
                    rem_d   = r_step[N-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed cases with literal results,
// then randomized traffic compared every cycle against a plain-arithmetic model.
module tb_shift_sub_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    shift_sub_divider #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .busy_o       (busy),
        .done_o       (done),
        .div_by_zero_o(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results come from / and %, timing from the cycle count alone.
    int  mCalcLeft = 0;
    bit  mDone = 0;
    int  mQ = 0, mR = 0, pendQ = 0, pendR = 0;
    bit  mDbz = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCalcLeft = 0;
            mDone = 0;
            mQ = 0;
            mR = 0;
            mDbz = 0;
        end else if (mDone) begin
            mDone = 0;
        end else if (mCalcLeft > 0) begin
            mCalcLeft--;
            if (mCalcLeft == 0) begin
                mDone = 1;
                mQ = pendQ;
                mR = pendR;
            end
        end else if (start) begin
            if (divisor == 0) begin
                mDone = 1;
                mQ = (1 << N) - 1;
                mR = int'(dividend);
                mDbz = 1;
            end else begin
                pendQ = int'(dividend) / int'(divisor);
                pendR = int'(dividend) % int'(divisor);
                mDbz = 0;
                mCalcLeft = N;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", int'(busy), int'(mDone || mCalcLeft > 0));
        checkOutput("done", int'(done), int'(mDone));
        checkOutput("quotient", int'(quotient), mQ);
        checkOutput("remainder", int'(remainder), mR);
        checkOutput("div_by_zero", int'(div_by_zero), int'(mDbz));
    end

    task automatic applyStimulus(input int a, input int b, input int expQ, input int expR,
                                 input int expZ, input int expCycles, input string name);
        int cycles = 0;
        int busyCnt = 0;
        @(negedge clk);
        dividend = N'(a);
        divisor  = N'(b);
        start    = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (busy) busyCnt++;
        end while (!done && cycles < 40);
        checkOutput({name, " done cycle"}, cycles, expCycles);
        checkOutput({name, " busy cycles"}, busyCnt, expCycles);
        checkOutput({name, " q"}, int'(quotient), expQ);
        checkOutput({name, " r"}, int'(remainder), expR);
        checkOutput({name, " dbz"}, int'(div_by_zero), expZ);
        @(negedge clk);
        checkOutput({name, " done width"}, int'(done), 0);
    endtask

    initial begin
        int cycles;
        int prev;
        int got;
        int t;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset q", int'(quotient), 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(100, 7, 14, 2, 0, N + 1, "100/7");
        applyStimulus(255, 1, 255, 0, 0, N + 1, "255/1");
        applyStimulus(5, 200, 0, 5, 0, N + 1, "5/200");
        applyStimulus(0, 9, 0, 0, 0, N + 1, "0/9");
        applyStimulus(42, 0, 255, 42, 1, 1, "42/0");
        applyStimulus(9, 3, 3, 0, 0, N + 1, "9/3 clears dbz");

        // A second start during CALC must be ignored.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("ignored start q", int'(quotient), 14);
        checkOutput("ignored start r", int'(remainder), 2);
        @(negedge clk);

        // Reset in the middle of a calculation.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort q", int'(quotient), 0);
        checkOutput("abort r", int'(remainder), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(200, 16, 12, 8, 0, N + 1, "200/16 after reset");

        // Held start: back-to-back operations with one idle cycle between them.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        t = 0;
        prev = -1;
        got = 0;
        while (got < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (prev >= 0) checkOutput("held start gap", t - prev, N + 2);
                prev = t;
                got++;
                dividend = N'($urandom);
                divisor  = N'($urandom_range(1, 255));
                @(negedge clk);
                t++;
                checkOutput("held start width", int'(done), 0);
                if (got == 3) start = 1'b0;
            end
        end
        checkOutput("held start count", got, 3);
        start = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            dividend = N'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            if (i == 1000) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
